// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
// ID-stage control decoder with a registered control word and multiply
// occupancy tracking.
//
// Each cycle the opcode in ID is decoded and the resulting control word is
// registered, so it appears one cycle after opCode is sampled. A bubble
// (every control bit 0, out_valid=0) is registered instead when reset, flush,
// an active multiply, hazard_detected or in_valid=0 applies (in that priority).
// An accepted MULT keeps EXE occupied for MULT_LAT cycles. stall_req holds
// IF/ID for the extra MULT_LAT-1 cycles.
//
// Handshake: in_valid qualifies opCode in the cycle it is sampled. Nothing is
// acknowledged back. While stall_req=1 the upstream stage must hold its
// instruction, and opCode is ignored here. out_valid qualifies the registered
// control word and is 1 for exactly one cycle per accepted instruction.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous, active-low reset
//   opCode          opcode of the instruction in ID
//   in_valid        opCode holds a real instruction
//   hazard_detected data hazard, turn the current instruction into a bubble
//   flush           taken branch downstream, turn it into a bubble
//   EXE_CMD         registered ALU command
//   branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN  registered bits
//   Branch_command  registered branch condition
//   out_valid       registered word is a real instruction
//   stall_req       combinational, 1 while a multiply occupies EXE
//   illegal_op      one-cycle pulse, an undefined opcode was accepted

`ifndef OP_CODE_LEN
`define OP_CODE_LEN 6
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

`ifndef OP_ADD
`define OP_ADD  1
`define OP_MULT 2
`define OP_SUB  3
`define OP_AND  5
`define OP_OR   6
`define OP_NOR  7
`define OP_XOR  8
`define OP_SLA  9
`define OP_SLL  10
`define OP_SRA  11
`define OP_SRL  12
`define OP_ADDI 32
`define OP_SUBI 33
`define OP_ANDI 34
`define OP_ORI  35
`define OP_LD   36
`define OP_ST   37
`define OP_XORI 38
`define OP_BEZ  40
`define OP_BNE  41
`define OP_JMP  42
`endif

`ifndef EXE_ADD
`define EXE_ADD          0
`define EXE_SUB          1
`define EXE_AND          2
`define EXE_OR           3
`define EXE_NOR          4
`define EXE_XOR          5
`define EXE_SLA          6
`define EXE_SLL          7
`define EXE_SRA          8
`define EXE_SRL          9
`define EXE_MULT         10
`define EXE_NO_OPERATION 15
`endif

`ifndef COND_BEZ
`define COND_BEZ  1
`define COND_BNE  2
`define COND_JUMP 3
`endif

module decode_ctrl_pipe #(
    parameter int OP_LEN   = `OP_CODE_LEN,
    parameter int CMD_LEN  = `EXE_CMD_LEN,
    parameter int MULT_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_LEN-1:0]  opCode,
    input  logic               in_valid,
    input  logic               hazard_detected,
    input  logic               flush,
    output logic [CMD_LEN-1:0] EXE_CMD,
    output logic               branchEn,
    output logic               Is_Imm,
    output logic               ST_or_BNE,
    output logic               WB_EN,
    output logic               MEM_R_EN,
    output logic               MEM_W_EN,
    output logic [1:0]         Branch_command,
    output logic               out_valid,
    output logic               stall_req,
    output logic               illegal_op
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    typedef enum logic {RUN = 1'b0, MULT_BUSY = 1'b1} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic               accept;
    logic               known;
    logic               is_mult;
    logic [CMD_LEN-1:0] d_cmd;
    logic               d_br, d_imm, d_st, d_wb, d_mr, d_mw;
    logic [1:0]         d_bc;

    // Flush and hazard outrank decode; a busy multiply outranks both in
    // effect because it also ignores opCode and must not be aborted.
    assign accept = in_valid && !flush && (state == RUN) && !hazard_detected;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic. A MULT_LAT of 1 loads 0 and never leaves RUN.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (accept && is_mult) begin
                    cnt_nx = CNT_W'(MULT_LAT - 1);
                    if (cnt_nx != '0) state_nx = MULT_BUSY;
                end
            end
            MULT_BUSY: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt_nx == '0) state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output logic: raw decode table plus the combinational stall.
    always_comb begin
        d_cmd   = '0;
        d_br    = 1'b0;
        d_imm   = 1'b0;
        d_st    = 1'b0;
        d_wb    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_bc    = 2'd0;
        known   = 1'b1;
        case (opCode)
            OP_LEN'(`OP_ADD):  begin d_cmd = CMD_LEN'(`EXE_ADD);  d_wb = 1'b1; end
            OP_LEN'(`OP_SUB):  begin d_cmd = CMD_LEN'(`EXE_SUB);  d_wb = 1'b1; end
            OP_LEN'(`OP_AND):  begin d_cmd = CMD_LEN'(`EXE_AND);  d_wb = 1'b1; end
            OP_LEN'(`OP_OR):   begin d_cmd = CMD_LEN'(`EXE_OR);   d_wb = 1'b1; end
            OP_LEN'(`OP_NOR):  begin d_cmd = CMD_LEN'(`EXE_NOR);  d_wb = 1'b1; end
            OP_LEN'(`OP_XOR):  begin d_cmd = CMD_LEN'(`EXE_XOR);  d_wb = 1'b1; end
            OP_LEN'(`OP_SLA):  begin d_cmd = CMD_LEN'(`EXE_SLA);  d_wb = 1'b1; end
            OP_LEN'(`OP_SLL):  begin d_cmd = CMD_LEN'(`EXE_SLL);  d_wb = 1'b1; end
            OP_LEN'(`OP_SRA):  begin d_cmd = CMD_LEN'(`EXE_SRA);  d_wb = 1'b1; end
            OP_LEN'(`OP_SRL):  begin d_cmd = CMD_LEN'(`EXE_SRL);  d_wb = 1'b1; end
            OP_LEN'(`OP_MULT): begin d_cmd = CMD_LEN'(`EXE_MULT); d_wb = 1'b1; end
            OP_LEN'(`OP_ADDI): begin d_cmd = CMD_LEN'(`EXE_ADD); d_wb = 1'b1; d_imm = 1'b1; end
            OP_LEN'(`OP_SUBI): begin d_cmd = CMD_LEN'(`EXE_SUB); d_wb = 1'b1; d_imm = 1'b1; end
            OP_LEN'(`OP_ANDI): begin d_cmd = CMD_LEN'(`EXE_AND); d_wb = 1'b1; d_imm = 1'b1; end
            OP_LEN'(`OP_ORI):  begin d_cmd = CMD_LEN'(`EXE_OR);  d_wb = 1'b1; d_imm = 1'b1; end
            OP_LEN'(`OP_XORI): begin d_cmd = CMD_LEN'(`EXE_XOR); d_wb = 1'b1; d_imm = 1'b1; end
            OP_LEN'(`OP_LD): begin
                d_cmd = CMD_LEN'(`EXE_ADD);
                d_wb  = 1'b1;
                d_imm = 1'b1;
                d_st  = 1'b1;
                d_mr  = 1'b1;
            end
            OP_LEN'(`OP_ST): begin
                d_cmd = CMD_LEN'(`EXE_ADD);
                d_imm = 1'b1;
                d_st  = 1'b1;
                d_mw  = 1'b1;
            end
            OP_LEN'(`OP_BEZ): begin
                d_cmd = CMD_LEN'(`EXE_NO_OPERATION);
                d_imm = 1'b1;
                d_br  = 1'b1;
                d_bc  = 2'(`COND_BEZ);
            end
            OP_LEN'(`OP_BNE): begin
                d_cmd = CMD_LEN'(`EXE_NO_OPERATION);
                d_imm = 1'b1;
                d_br  = 1'b1;
                d_st  = 1'b1;
                d_bc  = 2'(`COND_BNE);
            end
            OP_LEN'(`OP_JMP): begin
                d_cmd = CMD_LEN'(`EXE_NO_OPERATION);
                d_imm = 1'b1;
                d_br  = 1'b1;
                d_bc  = 2'(`COND_JUMP);
            end
            default: known = 1'b0;
        endcase
    end

    assign is_mult   = (opCode == OP_LEN'(`OP_MULT));
    assign stall_req = (state == MULT_BUSY);

    // Control word register. Anything that is not an accepted, defined
    // opcode registers an all-zero bubble.
    always_ff @(posedge clk) begin
        if (!rst || !(accept && known)) begin
            EXE_CMD        <= '0;
            branchEn       <= 1'b0;
            Is_Imm         <= 1'b0;
            ST_or_BNE      <= 1'b0;
            WB_EN          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            MEM_W_EN       <= 1'b0;
            Branch_command <= 2'd0;
            out_valid      <= 1'b0;
        end else begin
            EXE_CMD        <= d_cmd;
            branchEn       <= d_br;
            Is_Imm         <= d_imm;
            ST_or_BNE      <= d_st;
            WB_EN          <= d_wb;
            MEM_R_EN       <= d_mr;
            MEM_W_EN       <= d_mw;
            Branch_command <= d_bc;
            out_valid      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) illegal_op <= 1'b0;
        else      illegal_op <= accept && !known;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 The block SHALL have a parameter OP_LEN, default `OP_CODE_LEN, giving the opcode width.
REQ-002 The block SHALL have a parameter CMD_LEN, default `EXE_CMD_LEN, giving the EXE_CMD width.
REQ-003 The block SHALL have a parameter MULT_LAT, default 4, range 1..16, giving the multiply occupancy in cycles.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low; sampled on the clk rising edge.
REQ-006 opCode  input  OP_LEN  opcode of the instruction in ID.
REQ-007 in_valid  input  1  opCode holds a real instruction.
REQ-008 hazard_detected  input  1  data hazard; the current instruction must become a bubble.
REQ-009 flush  input  1  taken branch downstream; the current instruction must become a bubble.
REQ-010 EXE_CMD  output  CMD_LEN  registered ALU command.
REQ-011 branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN  output  1 each  registered control bits.
REQ-012 Branch_command  output  2  registered branch condition.
REQ-013 out_valid  output  1  the registered control word is a real instruction.
REQ-014 stall_req  output  1  hold IF/ID while a multiply occupies EXE.
REQ-015 illegal_op  output  1  one-cycle pulse: an undefined opcode was accepted.

Function
REQ-016 The control word SHALL be registered, appearing one cycle after opCode is sampled (latency 1).
REQ-017 Decode SHALL follow `OP_* to `EXE_* as follows:
- R-type ADD/SUB/AND/OR/NOR/XOR/SLA/SLL/SRA/SRL/MULT: WB_EN=1.
- ADDI/SUBI/ANDI/ORI: WB_EN=1, Is_Imm=1.
- XORI: EXE_CMD=`EXE_XOR, WB_EN=1, Is_Imm=1.
- LD: EXE_ADD, WB_EN, Is_Imm, ST_or_BNE, MEM_R_EN.
- ST: EXE_ADD, Is_Imm, ST_or_BNE, MEM_W_EN.
- BEZ: `EXE_NO_OPERATION, Is_Imm, branchEn, Branch_command=`COND_BEZ.
- BNE: as BEZ with `COND_BNE and ST_or_BNE=1.
- JMP: as BEZ with `COND_JUMP.
REQ-018 Every control bit not listed for an opcode SHALL be 0.
REQ-019 A bubble SHALL be all control outputs 0 with out_valid=0.
REQ-020 Per cycle, the priority SHALL be: reset > flush > busy (counter nonzero) > hazard_detected > in_valid=0 > decode.
REQ-021 The block SHALL register a bubble when any condition above decode in REQ-020 holds.
REQ-022 An undefined opcode with in_valid=1 and no higher-priority condition SHALL register a bubble and pulse illegal_op=1 for one cycle.
REQ-023 The block SHALL have FSM states RUN and MULT_BUSY and a down-counter cnt of width clog2(MULT_LAT+1).
REQ-024 In RUN, decoding MULT (out_valid=1) SHALL load cnt=MULT_LAT-1 and enter MULT_BUSY if that value is nonzero; otherwise it SHALL stay in RUN.
REQ-025 In MULT_BUSY, cnt SHALL decrement by 1 per cycle, and the FSM SHALL return to RUN in the cycle cnt reaches 0.
REQ-026 stall_req SHALL be combinational: 1 iff state is MULT_BUSY.
REQ-027 In MULT_BUSY, opCode SHALL be ignored and bubbles registered, so a MULT yields exactly MULT_LAT-1 stall cycles.
REQ-028 flush SHALL NOT abort MULT_BUSY or alter cnt.
REQ-029 A MULT sampled with flush=1 or hazard_detected=1 SHALL NOT start MULT_BUSY.
REQ-030 Back-to-back MULTs SHALL each be accepted only in RUN.
REQ-031 A MULT accepted in the cycle the FSM returns to RUN SHALL reload cnt.

Reset
REQ-032 While rst=0 at a clk edge, all control outputs, out_valid and illegal_op SHALL be 0, state SHALL be RUN and cnt SHALL be 0.
REQ-033 Reset asserted mid-MULT_BUSY SHALL terminate the stall; stall_req SHALL be 0 the cycle after the reset edge.
REQ-034 Outputs SHALL be valid from the first edge after rst=1.

Verification
REQ-035 Scenario: rst=0 for 2 cycles with in_valid=1 and opCode=`OP_ADD -> all outputs 0, stall_req=0.
REQ-036 Scenario: `OP_LD with in_valid=1, then idle -> next cycle EXE_CMD=`EXE_ADD, WB_EN=Is_Imm=ST_or_BNE=MEM_R_EN=1, MEM_W_EN=0, out_valid=1; the following cycle is a bubble.
REQ-037 Scenario: `OP_XORI -> EXE_CMD=`EXE_XOR, WB_EN=1, Is_Imm=1.
REQ-038 Scenario: `OP_BNE with hazard_detected=1, then without -> first a bubble; then branchEn=1, Branch_command=`COND_BNE, ST_or_BNE=1.
REQ-039 Scenario: MULT_LAT=4, `OP_MULT then `OP_ADD held -> MULT word, then stall_req=1 for exactly 3 cycles with bubbles, then the ADD word.
REQ-040 Scenario: flush=1 during the 2nd stall cycle -> stall still ends on schedule.
REQ-041 Scenario: rst=0 during the 2nd stall cycle -> stall_req=0 the next cycle.
REQ-042 Scenario: an undefined opcode such as all-ones -> illegal_op=1 for one cycle, bubble registered.
